// File: rtl/onchip_mem_arbiter_if.sv
// rtl/onchip_mem_arbiter_if.sv - bus bundle for two Avalon-MM masters and the shared RAM port
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic [ADDR_W-1:0] a_address;
  logic [BE_W-1:0]   a_byteenable;
  logic              a_read;
  logic              a_write;
  logic [DATA_W-1:0] a_writedata;
  logic              a_waitrequest;
  logic [DATA_W-1:0] a_readdata;
  logic              a_readdatavalid;

  logic [ADDR_W-1:0] b_address;
  logic [BE_W-1:0]   b_byteenable;
  logic              b_read;
  logic              b_write;
  logic [DATA_W-1:0] b_writedata;
  logic              b_waitrequest;
  logic [DATA_W-1:0] b_readdata;
  logic              b_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  a_address, a_byteenable, a_read, a_write, a_writedata,
    output a_waitrequest, a_readdata, a_readdatavalid,
    input  b_address, b_byteenable, b_read, b_write, b_writedata,
    output b_waitrequest, b_readdata, b_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport master (
    output a_address, a_byteenable, a_read, a_write, a_writedata,
    input  a_waitrequest, a_readdata, a_readdatavalid,
    output b_address, b_byteenable, b_read, b_write, b_writedata,
    input  b_waitrequest, b_readdata, b_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - round-robin two-master arbiter with bounded hold for a single-port RAM
module onchip_mem_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int BE_W     = 4,
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input logic                  clk,
  input logic                  reset,
  onchip_mem_arbiter_if.slave  bus
);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  logic             owner_q, owner_d;  // 1 = master B
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdv_a_q, rdv_a_d;
  logic             rdv_b_q, rdv_b_d;
  logic             req_a, req_b, grant_a, grant_b, hold_owner;

  always_comb begin
    req_a      = bus.a_read | bus.a_write;
    req_b      = bus.b_read | bus.b_write;
    hold_owner = (cnt_q != '0) && (cnt_q < HOLD_MAX);
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    if (!reset) begin
      if (req_a && req_b) begin
        grant_b = hold_owner ? owner_q : ~owner_q;
        grant_a = ~grant_b;
      end else begin
        grant_a = req_a;
        grant_b = req_b;
      end
    end
  end

  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (!(grant_a || grant_b)) begin
      cnt_d = '0;
    end else if (grant_b == owner_q) begin
      cnt_d = (cnt_q == HOLD_MAX) ? HOLD_MAX : cnt_q + 1'b1;
    end else begin
      owner_d = grant_b;
      cnt_d   = CNT_W'(1);
    end
    rdv_a_d = grant_a & bus.a_read & ~bus.a_write;
    rdv_b_d = grant_b & bus.b_read & ~bus.b_write;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= 1'b1;
      cnt_q   <= '0;
      rdv_a_q <= 1'b0;
      rdv_b_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rdv_a_q <= rdv_a_d;
      rdv_b_q <= rdv_b_d;
    end
  end

  always_comb begin
    bus.a_waitrequest = req_a & ~grant_a;
    bus.b_waitrequest = req_b & ~grant_b;
    bus.mem_chipselect = grant_a | grant_b;
    bus.mem_write      = (grant_a & bus.a_write) | (grant_b & bus.b_write);
    bus.mem_clken      = 1'b1;
    bus.mem_address    = '0;
    bus.mem_byteenable = '0;
    bus.mem_writedata  = '0;
    if (grant_a) begin
      bus.mem_address    = bus.a_address;
      bus.mem_byteenable = bus.a_byteenable;
      bus.mem_writedata  = bus.a_writedata;
    end else if (grant_b) begin
      bus.mem_address    = bus.b_address;
      bus.mem_byteenable = bus.b_byteenable;
      bus.mem_writedata  = bus.b_writedata;
    end
    // A read in flight when reset arrives is dropped without its strobe.
    bus.a_readdatavalid = rdv_a_q & ~reset;
    bus.b_readdatavalid = rdv_b_q & ~reset;
    bus.a_readdata      = bus.a_readdatavalid ? bus.mem_readdata : '0;
    bus.b_readdata      = bus.b_readdatavalid ? bus.mem_readdata : '0;
  end
endmodule
